demux_rr_n: RTL
===============

Name: demux_rr_n

Overview:
Parametrised successor to the two-way 8-bit demux. It distributes a single valid-qualified input stream across NCH output channels. Each channel has its own show-ahead FIFO, so downstream consumers can drain independently. Distribution is round-robin or explicit-destination, selected at run time, and backpressure is presented upstream through in_ready.

Parameters:
WIDTH, 8, data word width in bits (>=2)
NCH, 4, number of output channels (>=2)
DEPTH, 4, entries per channel FIFO (power of 2, >=2)

Ports:
clk  input  1  single clock, rising edge
reset_L  input  1  asynchronous, active-low reset
data_in  input  WIDTH  input word
valid_in  input  1  data_in is valid this cycle
sel_mode  input  1  0 = round-robin, 1 = destination taken from data_in MSBs
in_ready  output  1  word is accepted this cycle when valid_in && in_ready
pop  input  NCH  per-channel consume strobe
data_out  output  NCH*WIDTH  channel i head word at bits [i*WIDTH +: WIDTH]
valid_out  output  NCH  channel i FIFO non-empty
fifo_full  output  NCH  channel i FIFO holds DEPTH words
drop_err  output  1  one-cycle pulse when a word is discarded (mode 1, bad destination)

Behaviour:
- SELW = clog2(NCH), a localparam. CW = clog2(DEPTH+1) is the per-channel count width.
- Target channel:
  - Mode 0: target = rr_ptr.
  - Mode 1: target = data_in[WIDTH-1 -: SELW].
- in_ready is combinational: in_ready = !fifo_full[target]. When a mode-1 destination is >= NCH, in_ready = 1.
- Accept: valid_in && in_ready at a clock edge writes data_in into the target FIFO tail.
  - Mode 0 only: rr_ptr advances on accept, wrapping NCH-1 -> 0.
  - rr_ptr never advances on a stalled cycle, when valid_in=0, or in mode 1.
  - rr_ptr keeps its value across mode changes.
- Bad destination (mode 1, destination >= NCH; only possible when NCH is not a power of 2): the word is accepted and discarded. drop_err = 1 for the following cycle, and no FIFO changes.
- Latency: a word accepted at edge k is visible on valid_out/data_out after edge k, i.e. in cycle k+1.
  - FIFO operation is show-ahead: data_out shows the head word while valid_out = 1.
  - data_out for a channel is forced to 0 while that channel is empty.
- Pop: pop[i] && valid_out[i] removes the head at the edge. pop[i] on an empty channel is ignored and has no error effect.
- Simultaneous push and pop on the same non-full, non-empty channel: count is unchanged and FIFO order is preserved.
- Full channel: push is blocked even if pop[i] is asserted in the same cycle (no bypass). in_ready rises in the cycle after the pop.
- Empty channel with a simultaneous push and pop: the pop is ignored and the push lands.
- Pointers wrap modulo DEPTH. fifo_full[i] = (count_i == DEPTH).
- Channels are fully independent; one full channel stalls only words targeting it.
- Reset (asynchronous, any time including mid-transfer):
  - All FIFOs are emptied and contents discarded; counts = 0.
  - rr_ptr = 0.
  - Outputs: valid_out = 0, data_out = 0, fifo_full = 0, drop_err = 0, in_ready = 1.
- sel_mode must only change in cycles with valid_in = 0. Changing it with valid_in = 1 is illegal; behaviour is defined only in that the word still goes to the target computed from the current sel_mode.

Optional Feature:
DEMUX_RR_STATS_EN
- Defined: adds output port stall_count[15:0].
  - Increments each cycle where valid_in && !in_ready.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. NCH=4, DEPTH=4, mode 0, pop=0: push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> heads ch0..ch3 = 0x11,0x22,0x33,0x44; ch0 count 2; rr_ptr=1; valid_out=4'b1111.
2. Mode 1: push 0x01,0x02,0x03,0x04 (dest 0) -> fifo_full[0]=1. Push 0x05 -> in_ready=0 and it stalls. pop[0] for one cycle -> 0x05 accepted the next cycle. Popping ch0 then yields 0x02,0x03,0x04,0x05.
3. NCH=3, mode 1: push 0xC7 (dest 3) -> drop_err = 1 for one cycle; valid_out unchanged at 3'b000. Push 0x87 (dest 2) -> data_out ch2 = 0x87.
4. Ch1 holds 0xA1,0xA2; push 0xA3 to ch1 while pop[1]=1 -> count stays 2; heads follow 0xA2 then 0xA3.
5. Ch2 holds 3 words, mode 0 mid-stream: assert reset_L=0 between edges -> valid_out=0 and data_out=0 immediately. After release, push 0x3C in mode 0 -> lands in ch0.
6. DEMUX_RR_STATS_EN: ch0 full, mode 1, valid_in=1 with data_in=0x09 for 10 cycles -> stall_count=10. Force 70000 stall cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/demux_rr_n.sv
// Round-robin / explicit-destination demux of one valid-qualified stream into NCH show-ahead FIFOs.
// Optional DEMUX_RR_STATS_EN adds a saturating upstream stall counter output.
module demux_rr_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  input  logic                 sel_mode,
  output logic                 in_ready,
  input  logic [NCH-1:0]       pop,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic [NCH-1:0]       valid_out,
  output logic [NCH-1:0]       fifo_full,
  output logic                 drop_err
`ifdef DEMUX_RR_STATS_EN
  ,
  output logic [15:0]          stall_count
`endif
);

  localparam int unsigned SELW = $clog2(NCH);
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned PW   = $clog2(DEPTH);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] dest;
  logic [SELW-1:0] target;
  logic            bad_dest;
  logic            accept;

  // Target selection; a bad mode-1 destination is always accepted and dropped.
  always_comb begin
    dest     = data_in[WIDTH-1 -: SELW];
    bad_dest = sel_mode && ({1'b0, dest} >= (SELW+1)'(NCH));
    target   = sel_mode ? dest : rr_ptr;
    in_ready = bad_dest || !fifo_full[target];
    accept   = valid_in && in_ready;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr   <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= accept && bad_dest;
      if (accept && !sel_mode)
        rr_ptr <= (rr_ptr == SELW'(NCH - 1)) ? '0 : rr_ptr + SELW'(1);
    end
  end

`ifdef DEMUX_RR_STATS_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      stall_count <= '0;
    else if (valid_in && !in_ready && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop_ok;

    // Full channel never sees a push (in_ready low); empty channel ignores pop.
    assign push      = accept && !bad_dest && (target == SELW'(i));
    assign pop_ok    = pop[i] && (count != '0);
    assign valid_out[i] = (count != '0);
    assign fifo_full[i] = (count == CW'(DEPTH));
    assign data_out[i*WIDTH +: WIDTH] = valid_out[i] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + PW'(1);
        if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop_ok})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
    end
  end

endmodule
